dest_fifo_bank: RTL and testbench

// Receive side of the 4-port routing crossbar. Accepts the four routed 10-bit

---
 rtl/dest_fifo_bank_if.sv | 26 ++
 rtl/dest_fifo_bank.sv | 78 +++++++
 tb/tb_dest_fifo_bank.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dest_fifo_bank_if.sv
// Bundle of the four routed input words, pop requests and per-destination FIFO status/outputs.
// Vectors are indexed by port/destination number 0..3.
interface dest_fifo_bank_if #(
  parameter int WIDTH = 10,
  parameter int AW    = 2
);
  logic [3:0][WIDTH-1:0] word;
  logic [3:0]            pop;
  logic [3:0][WIDTH-1:0] data_out;
  logic [3:0]            valid_out;
  logic [3:0]            empty;
  logic [3:0]            full;
  logic [3:0][AW:0]      count;
  logic [3:0]            err_ovf;
  logic [3:0]            err_dest;

  modport master (
    output word, pop,
    input  data_out, valid_out, empty, full, count, err_ovf, err_dest
  );

  modport slave (
    input  word, pop,
    output data_out, valid_out, empty, full, count, err_ovf, err_dest
  );
endinterface

// File: rtl/dest_fifo_bank.sv
// Per-destination receive FIFOs: tag-checked push, registered pop data one cycle after pop,
// push accepted when full only alongside a pop; drops raise sticky err_ovf/err_dest bits.
module dest_fifo_bank #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic             clk,
  input logic             reset,
  dest_fifo_bank_if.slave bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  for (genvar n = 0; n < 4; n++) begin : g_port
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic [WIDTH-1:0] dout;
    logic             vout;
    logic             ovf;
    logic             dest;
    logic             push_req;
    logic             tag_ok;
    logic             pop_ok;
    logic             push_ok;

    // A pop frees the head slot at the same edge, so a full FIFO may still accept.
    always_comb begin
      push_req = |bus.word[n];
      tag_ok   = (bus.word[n][WIDTH-1 -: 2] == 2'(n));
      pop_ok   = bus.pop[n] && (cnt != '0);
      push_ok  = push_req && tag_ok && ((cnt != FULL_CNT) || pop_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
        dout <= '0;
        vout <= 1'b0;
        ovf  <= 1'b0;
        dest <= 1'b0;
      end else begin
        if (push_ok)
          wptr <= wptr + 1'b1;
        if (pop_ok)
          rptr <= rptr + 1'b1;
        if (push_ok && !pop_ok)
          cnt <= cnt + 1'b1;
        else if (!push_ok && pop_ok)
          cnt <= cnt - 1'b1;
        dout <= pop_ok ? mem[rptr] : '0;
        vout <= pop_ok;
        if (push_req && !tag_ok)
          dest <= 1'b1;
        if (push_req && tag_ok && !push_ok)
          ovf <= 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (push_ok)
        mem[wptr] <= bus.word[n];
    end

    assign bus.data_out[n]  = dout;
    assign bus.valid_out[n] = vout;
    assign bus.count[n]     = cnt;
    assign bus.empty[n]     = (cnt == '0);
    assign bus.full[n]      = (cnt == FULL_CNT);
    assign bus.err_ovf[n]   = ovf;
    assign bus.err_dest[n]  = dest;
  end

endmodule

// File: tb/tb_dest_fifo_bank.sv
// Randomized and directed bench for dest_fifo_bank against a queue-based reference model.
module tb_dest_fifo_bank;
  localparam int W = 10;
  localparam int D = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dest_fifo_bank_if #(.WIDTH(W), .AW(AW)) bus ();

  dest_fifo_bank #(.WIDTH(W), .DEPTH(D), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per destination plus expected registered outputs.
  logic [W-1:0] q [4][$];
  logic [W-1:0] exp_data [4];
  logic [3:0]   exp_valid;
  logic [3:0]   exp_ovf;
  logic [3:0]   exp_dest;

  task automatic model_clear();
    for (int n = 0; n < 4; n++) begin
      q[n].delete();
      exp_data[n] = '0;
    end
    exp_valid = '0;
    exp_ovf   = '0;
    exp_dest  = '0;
  endtask

  // Apply one cycle of inputs, clock once, and advance the model.
  task automatic cycle(input logic [W-1:0] w0, input logic [W-1:0] w1,
                       input logic [W-1:0] w2, input logic [W-1:0] w3,
                       input logic [3:0] p);
    logic [W-1:0] w [4];
    logic         pv;
    w = '{w0, w1, w2, w3};
    for (int n = 0; n < 4; n++) bus.word[n] = w[n];
    bus.pop = p;
    @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) begin
      pv = p[n] && (q[n].size() > 0);
      exp_valid[n] = pv;
      exp_data[n]  = pv ? q[n].pop_front() : '0;
      if (w[n] != '0) begin
        if (w[n][W-1 -: 2] != 2'(n))
          exp_dest[n] = 1'b1;
        else if (q[n].size() < D)
          q[n].push_back(w[n]);
        else
          exp_ovf[n] = 1'b1;
      end
    end
    bus.word = '0;
    bus.pop  = '0;
  endtask

  task automatic test_reset();
    cycle(10'h001, 0, 0, 0, 4'b0000);
    cycle(10'h002, 0, 0, 0, 4'b0000);
    cycle(10'h003, 0, 0, 0, 4'b0000);
    cycle(10'h004, 10'h2AA, 0, 0, 4'b0001);
    checks++;
    if (bus.count[0] !== 3'(q[0].size()) || bus.valid_out[0] !== 1'b1 || bus.err_dest !== exp_dest) begin
      errors++;
      $display("FAIL reset_pre: count0=%0d valid0=%b err_dest=%b required count0=%0d valid0=1 err_dest=%b",
               bus.count[0], bus.valid_out[0], bus.err_dest, q[0].size(), exp_dest);
    end
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    checks++;
    if (bus.count[0] !== 3'd0 || bus.empty[0] !== 1'b1 || bus.full[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count0=%0d empty0=%b full0=%b required 0/1/0",
               bus.count[0], bus.empty[0], bus.full[0]);
    end
    checks++;
    if (bus.valid_out !== 4'b0 || bus.data_out[0] !== '0 || bus.err_ovf !== 4'b0 || bus.err_dest !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data0=%h ovf=%b dest=%b required all zero",
               bus.valid_out, bus.data_out[0], bus.err_ovf, bus.err_dest);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (bus.empty !== 4'b1111 || bus.count[0] !== 3'd0) begin
      errors++;
      $display("FAIL reset_hold: empty=%b count0=%0d required 1111/0", bus.empty, bus.count[0]);
    end
  endtask

  task automatic test_order();
    cycle(0, 10'h101, 0, 0, 4'b0000);
    cycle(0, 10'h102, 0, 0, 4'b0000);
    cycle(0, 10'h103, 0, 0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 4'b0010);
      checks++;
      if (bus.valid_out[1] !== 1'b1 || bus.data_out[1] !== W'(10'h101 + i)) begin
        errors++;
        $display("FAIL order_pop%0d: valid1=%b data1=%h required 1/%h",
                 i, bus.valid_out[1], bus.data_out[1], 10'h101 + i);
      end
    end
    checks++;
    if (bus.empty[1] !== 1'b1) begin
      errors++;
      $display("FAIL order_empty: empty1=%b required 1", bus.empty[1]);
    end
    cycle(0, 0, 0, 0, 4'b0000);
    checks++;
    if (bus.valid_out[1] !== 1'b0 || bus.data_out[1] !== '0) begin
      errors++;
      $display("FAIL order_idle: valid1=%b data1=%h required 0/000", bus.valid_out[1], bus.data_out[1]);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, W'(10'h201 + i), 0, 4'b0000);
      if (i == 3) begin
        checks++;
        if (bus.full[2] !== 1'b1 || bus.count[2] !== 3'd4) begin
          errors++;
          $display("FAIL ovf_full: full2=%b count2=%0d required 1/4", bus.full[2], bus.count[2]);
        end
      end
    end
    checks++;
    if (bus.err_ovf !== 4'b0100) begin
      errors++;
      $display("FAIL ovf_flag: err_ovf=%b required 0100", bus.err_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 4'b0100);
      checks++;
      if (bus.data_out[2] !== W'(10'h201 + i) || bus.valid_out[2] !== 1'b1) begin
        errors++;
        $display("FAIL ovf_pop%0d: data2=%h valid2=%b required %h/1",
                 i, bus.data_out[2], bus.valid_out[2], 10'h201 + i);
      end
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, W'(10'h301 + i), 4'b0000);
    cycle(0, 0, 0, 10'h305, 4'b1000);
    checks++;
    if (bus.data_out[3] !== 10'h301 || bus.count[3] !== 3'd4 || bus.err_ovf[3] !== 1'b0) begin
      errors++;
      $display("FAIL fullpp: data3=%h count3=%0d ovf3=%b required 301/4/0",
               bus.data_out[3], bus.count[3], bus.err_ovf[3]);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 4'b1000);
      checks++;
      if (bus.data_out[3] !== W'(10'h302 + i)) begin
        errors++;
        $display("FAIL fullpp_drain%0d: data3=%h required %h", i, bus.data_out[3], 10'h302 + i);
      end
    end
  endtask

  task automatic test_bad_tag();
    cycle(10'h1AA, 0, 0, 0, 4'b0000);
    checks++;
    if (bus.count[0] !== 3'd0 || bus.err_dest !== 4'b0001) begin
      errors++;
      $display("FAIL badtag: count0=%0d err_dest=%b required 0/0001", bus.count[0], bus.err_dest);
    end
    cycle(10'h0AA, 0, 0, 0, 4'b0000);
    cycle(0, 0, 0, 0, 4'b0001);
    checks++;
    if (bus.data_out[0] !== 10'h0AA || bus.valid_out[0] !== 1'b1 || bus.err_dest !== 4'b0001) begin
      errors++;
      $display("FAIL badtag_next: data0=%h valid0=%b err_dest=%b required 0AA/1/0001",
               bus.data_out[0], bus.valid_out[0], bus.err_dest);
    end
  endtask

  task automatic test_wrap();
    cycle(0, 0, 0, 0, 4'b0001);
    checks++;
    if (bus.valid_out[0] !== 1'b0 || bus.data_out[0] !== '0) begin
      errors++;
      $display("FAIL empty_pop: valid0=%b data0=%h required 0/000", bus.valid_out[0], bus.data_out[0]);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(W'(10'h010 + i), 0, 0, 0, 4'b0001);
      checks++;
      if (bus.valid_out[0] !== exp_valid[0] || bus.data_out[0] !== exp_data[0] || bus.count[0] > 3'd1) begin
        errors++;
        $display("FAIL wrap%0d: valid0=%b data0=%h count0=%0d required %b/%h/<=1",
                 i, bus.valid_out[0], bus.data_out[0], bus.count[0], exp_valid[0], exp_data[0]);
      end
    end
    cycle(0, 0, 0, 0, 4'b0001);
    checks++;
    if (bus.data_out[0] !== 10'h019 || bus.empty[0] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_last: data0=%h empty0=%b required 019/1", bus.data_out[0], bus.empty[0]);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] w [4];
    logic [3:0]   p;
    logic [1:0]   tag;
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 4; n++) begin
        tag  = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'(n);
        w[n] = ($urandom_range(0, 3) == 0) ? '0 : {tag, 8'($urandom)};
      end
      p = 4'($urandom);
      cycle(w[0], w[1], w[2], w[3], p);
      for (int n = 0; n < 4; n++) begin
        checks++;
        if (bus.valid_out[n] !== exp_valid[n] || bus.data_out[n] !== exp_data[n] ||
            bus.count[n] !== 3'(q[n].size()) || bus.empty[n] !== (q[n].size() == 0) ||
            bus.full[n] !== (q[n].size() == D)) begin
          errors++;
          $display("FAIL rand c%0d p%0d: valid=%b data=%h count=%0d empty=%b full=%b required %b/%h/%0d/%b/%b",
                   c, n, bus.valid_out[n], bus.data_out[n], bus.count[n], bus.empty[n], bus.full[n],
                   exp_valid[n], exp_data[n], q[n].size(), q[n].size() == 0, q[n].size() == D);
        end
      end
      checks++;
      if (bus.err_ovf !== exp_ovf || bus.err_dest !== exp_dest) begin
        errors++;
        $display("FAIL rand_err c%0d: ovf=%b dest=%b required %b/%b",
                 c, bus.err_ovf, bus.err_dest, exp_ovf, exp_dest);
      end
    end
  endtask

  initial begin
    bus.word = '0;
    bus.pop  = '0;
    reset    = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_order();
    test_overflow();
    test_full_push_pop();
    test_bad_tag();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
